// File: rtl/ahb_fir_pkg.sv
// Shared types and constants for the FIR subsystem AHB-Lite fabric.
package ahb_fir_pkg;

  localparam int AHB_AWIDTH = 32;
  localparam int AHB_DWIDTH = 32;

  // AHB transfer type encoding
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // Initiator data-phase tracking
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_ACTIVE     = 2'b01,
    ST_ERR_CANCEL = 2'b10
  } ahb_mst_state_t;

  // HSIZE encoding for a full-width word of the given data width
  function automatic logic [2:0] hsize_for(input int dwidth);
    return 3'($clog2(dwidth / 8));
  endfunction

  localparam logic [2:0] HSIZE_WORD = hsize_for(AHB_DWIDTH);

endpackage

// File: rtl/ahb_mst.sv
// AHB-Lite initiator: valid/ready command stream to pipelined single NONSEQ
// word transfers, one in-order response per accepted command.
module ahb_mst
  import ahb_fir_pkg::*;
#(
  parameter int AWIDTH = ahb_fir_pkg::AHB_AWIDTH,
  parameter int DWIDTH = ahb_fir_pkg::AHB_DWIDTH
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [AWIDTH-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [DWIDTH-1:0] hwdata,
  input  logic [DWIDTH-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  // Byte-lane bits below the word boundary are dropped from every address
  localparam logic [AWIDTH-1:0] ALIGN_MASK = ~(AWIDTH'(DWIDTH / 8 - 1));
  localparam logic [2:0]        HSIZE_C    = hsize_for(DWIDTH);

  ahb_mst_state_t    state_r;
  htrans_t           htrans_r;
  logic [AWIDTH-1:0] haddr_r;
  logic              hwrite_r;
  logic [DWIDTH-1:0] ap_wdata_r;   // wdata travelling with the address phase (also the held command)
  logic [DWIDTH-1:0] hwdata_r;
  logic              dp_write_r;   // direction of the pending data phase
  logic              rsp_valid_r;
  logic [DWIDTH-1:0] rsp_rdata_r;
  logic              rsp_err_r;

  logic              cmd_ready_s;
  logic              fire_s;
  logic              ap_nonseq_s;

  // Command handshake and address-phase decode
  always_comb begin
    cmd_ready_s = hready & (state_r != ST_ERR_CANCEL);
    fire_s      = cmd_valid & cmd_ready_s;
    ap_nonseq_s = (htrans_r == HTRANS_NONSEQ);
  end

  // Pipeline FSM: address phase, data phase, response and two-cycle ERROR cancel
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_r     <= ST_IDLE;
      htrans_r    <= HTRANS_IDLE;
      haddr_r     <= {AWIDTH{1'b0}};
      hwrite_r    <= 1'b0;
      ap_wdata_r  <= {DWIDTH{1'b0}};
      hwdata_r    <= {DWIDTH{1'b0}};
      dp_write_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DWIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_ACTIVE: begin
          if (hready) begin
            if (state_r == ST_ACTIVE) begin
              rsp_valid_r <= 1'b1;
              rsp_rdata_r <= dp_write_r ? {DWIDTH{1'b0}} : hrdata;
              rsp_err_r   <= hresp;
            end
            if (ap_nonseq_s) begin
              dp_write_r <= hwrite_r;
              hwdata_r   <= ap_wdata_r;
              state_r    <= ST_ACTIVE;
            end else begin
              state_r    <= ST_IDLE;
            end
            if (fire_s) begin
              haddr_r    <= cmd_addr & ALIGN_MASK;
              hwrite_r   <= cmd_write;
              ap_wdata_r <= cmd_wdata;
              htrans_r   <= HTRANS_NONSEQ;
            end else begin
              htrans_r   <= HTRANS_IDLE;
            end
          end else if ((state_r == ST_ACTIVE) && hresp && ap_nonseq_s) begin
            // First ERROR cycle: cancel the queued transfer, keep it in haddr/hwrite/ap_wdata
            htrans_r <= HTRANS_IDLE;
            state_r  <= ST_ERR_CANCEL;
          end
        end
        ST_ERR_CANCEL: begin
          if (hready) begin
            // Second ERROR cycle: report the error and replay the held command
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= dp_write_r ? {DWIDTH{1'b0}} : hrdata;
            rsp_err_r   <= hresp;
            htrans_r    <= HTRANS_NONSEQ;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          htrans_r <= HTRANS_IDLE;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign haddr     = haddr_r;
  assign htrans    = htrans_r;
  assign hwrite    = hwrite_r;
  assign hsize     = HSIZE_C;
  assign hwdata    = hwdata_r;

endmodule

// File: tb/tb_ahb_mst.sv
// Directed self-checking bench for ahb_mst; the bench drives the slave side.
module tb_ahb_mst;

  logic        hclk;
  logic        hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int tests_run = 0;
  int fails     = 0;

  ahb_mst dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
    cyc(); cyc(); #1;
    tests_run++; if (htrans !== 2'b00) begin fails++; $display("FAIL rst_htrans got %h exp 0", htrans); end
    tests_run++; if (haddr !== 32'h0) begin fails++; $display("FAIL rst_haddr got %h exp 0", haddr); end
    tests_run++; if (hwrite !== 1'b0) begin fails++; $display("FAIL rst_hwrite got %b exp 0", hwrite); end
    tests_run++; if (hwdata !== 32'h0) begin fails++; $display("FAIL rst_hwdata got %h exp 0", hwdata); end
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    tests_run++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
    tests_run++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    tests_run++; if (hsize !== 3'b010) begin fails++; $display("FAIL rst_hsize got %h exp 2", hsize); end
    hresetn = 1'b1;
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = 32'hDEAD_BEEF; hready = 1'b1;
    #1;
    tests_run++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready); end
    cyc(); cmd_valid = 1'b0; #1;
    tests_run++; if (htrans !== 2'b10) begin fails++; $display("FAIL wr_htrans got %h exp 2", htrans); end
    tests_run++; if (haddr !== 32'h10) begin fails++; $display("FAIL wr_haddr got %h exp 10", haddr); end
    tests_run++; if (hwrite !== 1'b1) begin fails++; $display("FAIL wr_hwrite got %b exp 1", hwrite); end
    cyc(); #1;
    tests_run++; if (hwdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_hwdata got %h exp deadbeef", hwdata); end
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rsp_early got %b exp 0", rsp_valid); end
    cyc(); #1;
    tests_run++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL wr_rsp_valid got %b exp 1", rsp_valid); end
    tests_run++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL wr_rsp_err got %b exp 0", rsp_err); end
    tests_run++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL wr_rsp_rdata got %h exp 0", rsp_rdata); end
    cyc(); #1;
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rsp_pulse got %b exp 0", rsp_valid); end
    tests_run++; if (htrans !== 2'b00) begin fails++; $display("FAIL wr_htrans_idle got %h exp 0", htrans); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      cmd_valid = (k < 4); cmd_write = 1'b0; cmd_addr = 32'h20 + 32'(4 * k);
      hready = 1'b1; hresp = 1'b0;
      hrdata = (k >= 2 && k <= 5) ? 32'(k - 1) : 32'h0;
      #1;
      if (k >= 1 && k <= 4) begin
        tests_run++; if (htrans !== 2'b10) begin fails++; $display("FAIL b2b_htrans c%0d got %h exp 2", k, htrans); end
        tests_run++; if (haddr !== 32'h20 + 32'(4 * (k - 1))) begin fails++; $display("FAIL b2b_haddr c%0d got %h exp %h", k, haddr, 32'h20 + 32'(4 * (k - 1))); end
      end
      tests_run++; if (rsp_valid !== (k >= 3 && k <= 6)) begin fails++; $display("FAIL b2b_rsp_valid c%0d got %b exp %b", k, rsp_valid, (k >= 3 && k <= 6)); end
      if (k >= 3 && k <= 6) begin
        tests_run++; if (rsp_rdata !== 32'(k - 2)) begin fails++; $display("FAIL b2b_rdata c%0d got %h exp %h", k, rsp_rdata, 32'(k - 2)); end
        tests_run++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL b2b_err c%0d got %b exp 0", k, rsp_err); end
      end
      cyc();
    end
    cmd_valid = 1'b0; hrdata = 32'h0;
  endtask

  task automatic test_wait_states();
    for (int k = 0; k < 9; k++) begin
      cmd_valid = (k < 2); cmd_write = 1'b0; cmd_addr = 32'h40 + 32'(4 * k);
      hready = !(k >= 2 && k <= 4); hresp = 1'b0;
      hrdata = (k == 5) ? 32'hA5A5_0001 : ((k == 6) ? 32'hB0B0_0002 : 32'h0);
      #1;
      if (k >= 2 && k <= 5) begin
        tests_run++; if (htrans !== 2'b10) begin fails++; $display("FAIL ws_htrans c%0d got %h exp 2", k, htrans); end
        tests_run++; if (haddr !== 32'h44) begin fails++; $display("FAIL ws_haddr c%0d got %h exp 44", k, haddr); end
      end
      if (k == 3) begin
        tests_run++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL ws_cmd_ready got %b exp 0", cmd_ready); end
      end
      tests_run++; if (rsp_valid !== (k == 6 || k == 7)) begin fails++; $display("FAIL ws_rsp_valid c%0d got %b exp %b", k, rsp_valid, (k == 6 || k == 7)); end
      if (k == 6) begin
        tests_run++; if (rsp_rdata !== 32'hA5A5_0001) begin fails++; $display("FAIL ws_rdata_a got %h exp a5a50001", rsp_rdata); end
      end
      if (k == 7) begin
        tests_run++; if (rsp_rdata !== 32'hB0B0_0002) begin fails++; $display("FAIL ws_rdata_b got %h exp b0b00002", rsp_rdata); end
      end
      cyc();
    end
    cmd_valid = 1'b0; hready = 1'b1; hrdata = 32'h0;
  endtask

  task automatic test_error_cancel();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'h0000_1111; hready = 1'b1; hresp = 1'b0;
    cyc();
    cmd_write = 1'b0; cmd_addr = 32'h4; cmd_wdata = 32'h0;
    cyc();
    cmd_valid = 1'b0; hready = 1'b0; hresp = 1'b1; #1;
    tests_run++; if (htrans !== 2'b10 || haddr !== 32'h4) begin fails++; $display("FAIL err_ap1 got %h/%h exp 2/4", htrans, haddr); end
    tests_run++; if (hwdata !== 32'h0000_1111) begin fails++; $display("FAIL err_hwdata got %h exp 1111", hwdata); end
    cyc();
    hready = 1'b1; hresp = 1'b1; #1;
    tests_run++; if (htrans !== 2'b00) begin fails++; $display("FAIL err_htrans_cancel got %h exp 0", htrans); end
    tests_run++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL err_cmd_ready got %b exp 0", cmd_ready); end
    cyc();
    hresp = 1'b0; #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin fails++; $display("FAIL err_wr_rsp got v=%b e=%b exp 1/1", rsp_valid, rsp_err); end
    tests_run++; if (htrans !== 2'b10 || haddr !== 32'h4 || hwrite !== 1'b0) begin fails++; $display("FAIL err_replay got %h/%h/%b exp 2/4/0", htrans, haddr, hwrite); end
    cyc();
    hrdata = 32'h7777_0004; #1;
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL err_gap got %b exp 0", rsp_valid); end
    cyc();
    hrdata = 32'h0; #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin fails++; $display("FAIL err_rd_rsp got v=%b e=%b exp 1/0", rsp_valid, rsp_err); end
    tests_run++; if (rsp_rdata !== 32'h7777_0004) begin fails++; $display("FAIL err_rd_rdata got %h exp 77770004", rsp_rdata); end
    cyc();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'h1234_5678; hready = 1'b1; hresp = 1'b0;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    hready = 1'b0; #1;
    tests_run++; if (hwdata !== 32'h1234_5678) begin fails++; $display("FAIL rm_hwdata got %h exp 12345678", hwdata); end
    hresetn = 1'b0;
    cyc();
    hresetn = 1'b1; hready = 1'b1; #1;
    tests_run++; if (htrans !== 2'b00 || haddr !== 32'h0 || hwrite !== 1'b0) begin fails++; $display("FAIL rm_ap got %h/%h/%b exp 0/0/0", htrans, haddr, hwrite); end
    tests_run++; if (hwdata !== 32'h0) begin fails++; $display("FAIL rm_hwdata_rst got %h exp 0", hwdata); end
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rm_rsp0 got %b exp 0", rsp_valid); end
    cyc(); #1;
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rm_rsp1 got %b exp 0", rsp_valid); end
    cyc(); #1;
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rm_rsp2 got %b exp 0", rsp_valid); end
  endtask

  task automatic test_cmd_stall();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h103; hready = 1'b0; hresp = 1'b0; #1;
    tests_run++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL st_ready0 got %b exp 0", cmd_ready); end
    cyc(); #1;
    tests_run++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL st_ready1 got %b exp 0", cmd_ready); end
    tests_run++; if (htrans !== 2'b00) begin fails++; $display("FAIL st_htrans_hold got %h exp 0", htrans); end
    cyc();
    hready = 1'b1; #1;
    tests_run++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL st_ready2 got %b exp 1", cmd_ready); end
    cyc();
    cmd_valid = 1'b0; #1;
    tests_run++; if (htrans !== 2'b10) begin fails++; $display("FAIL st_htrans got %h exp 2", htrans); end
    tests_run++; if (haddr !== 32'h100) begin fails++; $display("FAIL st_haddr_align got %h exp 100", haddr); end
    cyc();
    hrdata = 32'h55;
    cyc();
    hrdata = 32'h0; #1;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55) begin fails++; $display("FAIL st_rsp got v=%b d=%h exp 1/55", rsp_valid, rsp_rdata); end
    cyc(); #1;
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL st_rsp_once got %b exp 0", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_wait_states();
    test_error_cancel();
    test_reset_mid();
    test_cmd_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
